uart_rx_8n1: RTL

UART_RX_8N1 -- requirements
Module: uart_rx_8n1

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_8n1.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART receiver.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 10417;  // 9600 baud at 100 MHz
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned STOP_BITS            = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to the idle-high level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling FSM, shift register and single-entry holding register.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] HalfTc = 16'((CLKS_PER_BIT >> 1) - 1);
  localparam logic [15:0] BitTc  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LastIdx = 3'(DATA_BITS - 1);

  logic rxs;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  rx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;
  logic        ack_ok;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    ovr_d   = ovr_q;
    ack_ok  = rx_ack & valid_q;

    if (ack_ok) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          timer_d = 16'd0;
        end
      end
      StStart: begin
        if (timer_q == HalfTc) begin
          // A high line at mid start bit is a glitch; drop back silently.
          state_d = rxs ? StIdle : StData;
          timer_d = 16'd0;
          idx_d   = 3'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StData: begin
        if (timer_q == BitTc) begin
          shift_d = {rxs, shift_q[7:1]};
          timer_d = 16'd0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StStop: begin
        if (timer_q == BitTc) begin
          state_d = StIdle;
          timer_d = 16'd0;
          if (rxs) begin
            // A same-cycle ack frees the holding register before the new byte lands.
            if (!valid_q || ack_ok) begin
              byte_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != StIdle);
  assign frame_err = err_q;
  assign overrun   = ovr_q;

endmodule
